// File: rtl/floo_link_slice.sv
// floo_link_slice: elastic valid/ready FIFO slice for one mesh link channel,
// with occupancy, flit and stall counters for link monitoring.
module floo_link_slice #(
   parameter int unsigned FlitWidth = 64,
   parameter int unsigned Depth     = 2,
   parameter int unsigned CntWidth  = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [FlitWidth-1:0]         in_data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [FlitWidth-1:0]         out_data_o,
   output logic [$clog2(Depth+1)-1:0]   occupancy_o,
   output logic [CntWidth-1:0]          flit_cnt_o,
   output logic [CntWidth-1:0]          stall_cnt_o,
   input  logic                         cnt_clr_i
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned OccW = $clog2(Depth+1);

   logic [FlitWidth-1:0] mem_q [Depth];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OccW-1:0]      occ_q, occ_d;
   logic [CntWidth-1:0]  flit_cnt_q, flit_cnt_d, stall_cnt_q, stall_cnt_d;
   logic                 push, pop;

   // Handshake flags come only from registered occupancy, so no path crosses the slice.
   assign in_ready_o  = occ_q != OccW'(Depth);
   assign out_valid_o = occ_q != '0;
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;
   assign out_data_o  = mem_q[rd_ptr_q];
   assign occupancy_o = occ_q;
   assign flit_cnt_o  = flit_cnt_q;
   assign stall_cnt_o = stall_cnt_q;

   always_comb begin
      wr_ptr_d    = push ? ((wr_ptr_q == PtrW'(Depth-1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
      rd_ptr_d    = pop ? ((rd_ptr_q == PtrW'(Depth-1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
      occ_d       = (push && !pop) ? occ_q + 1'b1 : (pop && !push) ? occ_q - 1'b1 : occ_q;
      flit_cnt_d  = cnt_clr_i ? '0 : flit_cnt_q + CntWidth'(pop);
      stall_cnt_d = cnt_clr_i ? '0
                  : (out_valid_o && !out_ready_i && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1
                  : stall_cnt_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         flit_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         flit_cnt_q  <= flit_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Payload storage carries no reset; contents are qualified by occupancy.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
   end
endmodule

// File: tb/tb_floo_link_slice.sv
// tb_floo_link_slice: randomized and directed checks of floo_link_slice
// against a queue-based reference model.
module tb_floo_link_slice;
   localparam int FW = 8;
   localparam int D  = 3;
   localparam int CW = 4;
   localparam int OW = $clog2(D+1);
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 0;
   logic          rst = 1;
   logic          in_valid = 0;
   logic          in_ready;
   logic [FW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 0;
   logic [FW-1:0] out_data;
   logic [OW-1:0] occupancy;
   logic [CW-1:0] flit_cnt, stall_cnt;
   logic          cnt_clr = 0;

   int n_tests = 0;
   int n_fail  = 0;
   logic [FW-1:0] q[$];
   int m_flit  = 0;
   int m_stall = 0;

   floo_link_slice #(.FlitWidth(FW), .Depth(D), .CntWidth(CW)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .occupancy_o(occupancy), .flit_cnt_o(flit_cnt), .stall_cnt_o(stall_cnt),
      .cnt_clr_i(cnt_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: checks outputs against the model, drives inputs for one cycle.
   task automatic cycle(input logic v, input logic [FW-1:0] d, input logic r, input logic clr);
      bit push, pop, stl;
      chk("in_ready", in_ready, q.size() < D);
      chk("out_valid", out_valid, q.size() != 0);
      chk("occupancy", occupancy, q.size());
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      chk("flit_cnt", flit_cnt, m_flit);
      chk("stall_cnt", stall_cnt, m_stall);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      cnt_clr   = clr;
      push = v && (q.size() < D);
      pop  = (q.size() != 0) && r;
      stl  = (q.size() != 0) && !r;
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      if (clr) begin
         m_flit  = 0;
         m_stall = 0;
      end else begin
         m_flit = (m_flit + int'(pop)) % (CMAX + 1);
         if (stl && m_stall < CMAX) m_stall++;
      end
      @(negedge clk);
   endtask

   initial begin
      logic          v, r, hold;
      logic [FW-1:0] d;
      in_valid = 1;
      in_data  = 8'hA5;
      out_ready = 1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_occ", occupancy, 0);
         chk("rst_cnts", {flit_cnt, stall_cnt}, 0);
      end
      rst = 0;
      cycle(1, 8'hA5, 1, 0);
      chk("lat_valid", out_valid, 1);
      chk("lat_data", out_data, 8'hA5);
      cycle(0, 8'h00, 1, 0);

      cycle(0, 8'h00, 1, 1);
      for (int i = 0; i < 100; i++) cycle(1, FW'(i), 1, 0);
      cycle(0, 8'h00, 1, 0);
      chk("stream_flits", flit_cnt, 100 % (CMAX + 1));
      chk("stream_stall", stall_cnt, 0);

      cycle(0, 8'h00, 1, 1);
      for (int i = 0; i < 6; i++) cycle(1, FW'(8'h40 + i), 0, 0);
      chk("full_ready", in_ready, 0);
      chk("full_occ", occupancy, D);
      cycle(1, 8'h43, 1, 0);
      chk("pop_frees", in_ready, 1);
      chk("no_push_full", occupancy, D - 1);
      cycle(1, 8'h43, 0, 0);
      chk("refill_occ", occupancy, D);

      for (int i = 0; i < 20; i++) cycle(0, 8'h00, 0, 0);
      chk("stall_sat", stall_cnt, CMAX);
      cycle(0, 8'h00, 1, 1);
      chk("clr_flit", flit_cnt, 0);
      chk("clr_stall", stall_cnt, 0);
      while (q.size() != 0) cycle(0, 8'h00, 1, 0);

      hold = 0;
      v = 0;
      d = '0;
      for (int i = 0; i < 400; i++) begin
         if (!hold) begin
            v = 1'($urandom_range(0, 1));
            d = FW'($urandom);
         end
         r = 1'($urandom_range(0, 2) != 0);
         hold = v && (q.size() >= D);
         cycle(v, d, r, 1'($urandom_range(0, 15) == 0));
      end
      for (int i = 0; i < 6; i++) cycle(0, 8'h00, 1, 0);

      cycle(1, 8'h11, 0, 0);
      cycle(1, 8'h22, 0, 0);
      #2 rst = 1;
      #1;
      chk("async_rst_occ", occupancy, 0);
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_ready", in_ready, 1);
      in_valid = 0;
      @(negedge clk);
      rst = 0;
      q.delete();
      m_flit  = 0;
      m_stall = 0;
      cycle(0, 8'h00, 1, 0);
      cycle(1, 8'h5A, 1, 0);
      cycle(0, 8'h00, 1, 0);
      cycle(0, 8'h00, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
